// File: rtl/gbsha_fir_driver.sv
// rtl/gbsha_fir_driver.sv - host-side sequencer driving the FIR core's reset/data pins
// Replays stored coefficients, then streams FIFO samples with zero-stuffing and tags outputs.
module gbsha_fir_driver #(
  parameter int N_TAPS     = 5,
  parameter int BW_in      = 6,
  parameter int BW_out     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [BW_in-1:0]  coef_data,
  input  logic              start,
  input  logic              stop,
  input  logic              s_valid,
  input  logic [BW_in-1:0]  s_data,
  output logic              s_ready,
  output logic              fir_reset,
  output logic [BW_in-1:0]  fir_x,
  input  logic [BW_out-1:0] fir_y,
  output logic              y_valid,
  output logic [BW_out-1:0] y_data,
  output logic              busy
);

  localparam int         PW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] NT      = 4'(N_TAPS);
  localparam logic [3:0] NT_M1   = 4'(N_TAPS - 1);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [3:0]          k_q, k_d, cnt_q, cnt_d;
  logic                fir_reset_q, fir_reset_d;
  logic [BW_in-1:0]    fir_x_q, fir_x_d;
  logic                tag_q, tag_d, tag_p_q, tag_p_d;
  logic                y_valid_q, y_valid_d;
  logic [BW_out-1:0]   y_data_q, y_data_d;
  // Bank is sized for the full 4-bit address space; only indices below N_TAPS are writable.
  logic [BW_in-1:0]    coef_q [16];
  logic [BW_in-1:0]    coef_d [16];
  logic [BW_in-1:0]    mem_q [FIFO_DEPTH];
  logic [BW_in-1:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]         count_q, count_d;
  logic                push, pop, fifo_empty, do_stream;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    fir_reset_d = fir_reset_q;
    fir_x_d     = fir_x_q;
    tag_d       = 1'b0;
    tag_p_d     = tag_q;
    y_valid_d   = tag_p_q;
    y_data_d    = fir_y;
    coef_d      = coef_q;
    pop         = 1'b0;
    fifo_empty  = (count_q == '0);
    do_stream   = (state_q == STREAM) || (state_q == LOAD && k_q == NT_M1);

    unique case (state_q)
      IDLE: begin
        fir_reset_d = 1'b1;
        fir_x_d     = '0;
        if (coef_we && coef_addr < NT) coef_d[coef_addr] = coef_data;
        // coef_q[0] is read before the same-edge write lands, so LOAD sees the old value.
        if (start) begin
          fir_reset_d = 1'b0;
          fir_x_d     = coef_q[0];
          k_d         = 4'd0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        k_d = k_q + 4'd1;
        if (k_q == NT_M1) state_d = STREAM;
        else              fir_x_d = coef_q[k_q + 4'd1];
      end
      STREAM: begin
        if (stop) begin
          state_d = FLUSH;
          cnt_d   = NT;
        end
      end
      FLUSH: begin
        fir_x_d = '0;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = IDLE;
          fir_reset_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The FIR shifts every cycle, so an empty FIFO feeds zeros rather than stalling.
    if (do_stream) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        fir_x_d = mem_q[rd_ptr_q];
        tag_d   = 1'b1;
      end else begin
        fir_x_d = '0;
      end
    end

    push     = s_valid && (count_q != DEPTH_C);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      fir_reset_q <= 1'b1;
      fir_x_q     <= '0;
      tag_q       <= 1'b0;
      tag_p_q     <= 1'b0;
      y_valid_q   <= 1'b0;
      y_data_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < 16; i++) coef_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      fir_reset_q <= fir_reset_d;
      fir_x_q     <= fir_x_d;
      tag_q       <= tag_d;
      tag_p_q     <= tag_p_d;
      y_valid_q   <= y_valid_d;
      y_data_q    <= y_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      coef_q      <= coef_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign s_ready   = (count_q != DEPTH_C);
  assign fir_reset = fir_reset_q;
  assign fir_x     = fir_x_q;
  assign y_valid   = y_valid_q;
  assign y_data    = y_data_q;
  assign busy      = (state_q != IDLE);

endmodule
